// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and data access.
// One transaction outstanding at a time; data has priority, bounded by an anti-starvation counter.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  typedef enum logic {OWN_INST, OWN_DATA} owner_t;

  state_t              state, state_nxt;
  owner_t              owner_p0;
  logic                wr_p0;
  logic [STRB_W-1:0]   wstrb_p0;
  logic [ADDR_W-1:0]   addr_p0;
  logic [DATA_W-1:0]   wdata_p0;
  logic [CNT_W-1:0]    starve_cnt;

  logic arb_pt;
  logic data_win;
  logic inst_win;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  endfunction

  // A new winner is picked whenever the port is free: idle, or on the response cycle.
  always_comb begin
    arb_pt   = (state == IDLE) || ((state == DATA) && mem_data_ok);
    data_win = data_req && !(inst_req && (starve_cnt == CNT_MAX));
    inst_win = inst_req && !data_win;
  end

  always_comb begin
    state_nxt    = state;
    mem_req      = 1'b0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    case (state)
      IDLE: ;
      ADDR: begin
        mem_req = 1'b1;
        if (mem_addr_ok) begin
          data_addr_ok = (owner_p0 == OWN_DATA);
          inst_addr_ok = (owner_p0 == OWN_INST);
          state_nxt    = DATA;
        end
      end
      DATA: begin
        if (mem_data_ok) begin
          data_data_ok = (owner_p0 == OWN_DATA);
          inst_data_ok = (owner_p0 == OWN_INST);
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (arb_pt) state_nxt = (data_win || inst_win) ? ADDR : IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Request fields latched at the arbitration point; memory sees only these.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner_p0   <= OWN_INST;
      wr_p0      <= 1'b0;
      wstrb_p0   <= '0;
      addr_p0    <= '0;
      wdata_p0   <= '0;
      starve_cnt <= '0;
    end else if (arb_pt) begin
      if (data_win) begin
        owner_p0   <= OWN_DATA;
        wr_p0      <= data_wr;
        wstrb_p0   <= data_wstrb;
        addr_p0    <= data_addr;
        wdata_p0   <= data_wdata;
        starve_cnt <= inst_req ? sat_inc(starve_cnt) : '0;
      end else if (inst_win) begin
        owner_p0   <= OWN_INST;
        wr_p0      <= 1'b0;
        wstrb_p0   <= '0;
        addr_p0    <= inst_addr;
        wdata_p0   <= '0;
        starve_cnt <= '0;
      end else begin
        starve_cnt <= '0;
      end
    end
  end

  assign mem_wr     = wr_p0;
  assign mem_wstrb  = wstrb_p0;
  assign mem_addr   = addr_p0;
  assign mem_wdata  = wdata_p0;
  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, collision, starvation, backpressure, reset abort.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              resetn;
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok, inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;
  logic              data_req, data_wr;
  logic [3:0]        data_wstrb;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok, data_data_ok;
  logic [DATA_W-1:0] data_rdata;
  logic              mem_req, mem_wr;
  logic [3:0]        mem_wstrb;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_addr_ok, mem_data_ok;
  logic [DATA_W-1:0] mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen mid-cycle.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  logic [ADDR_W-1:0] grants [6];
  int                ng;
  logic              pend;
  logic [ADDR_W-1:0] exp_grant [6];

  initial begin
    resetn = 1'b0; inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = '0; data_addr = '0; data_wdata = '0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 6; i++) grants[i] = '0;

    // Reset state
    next_cycle(); next_cycle();
    settle();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_ok", {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 0);
    chk("rst_mem_fields", {mem_wr, mem_wstrb, mem_addr, mem_wdata}, 0);
    next_cycle();
    resetn = 1'b1;
    next_cycle();

    // Single fetch
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
    settle();
    chk("fetch_c0_mem_req", mem_req, 0);
    next_cycle();
    mem_addr_ok = 1'b1;
    settle();
    chk("fetch_c1_mem_req", mem_req, 1);
    chk("fetch_c1_mem_wr", mem_wr, 0);
    chk("fetch_c1_mem_addr", mem_addr, 32'hBFC0_0000);
    chk("fetch_c1_addr_ok", {inst_addr_ok, data_addr_ok}, 2'b10);
    next_cycle();
    inst_req = 1'b0; mem_addr_ok = 1'b0;
    settle();
    chk("fetch_c2_idle", {mem_req, inst_data_ok}, 0);
    next_cycle();
    mem_data_ok = 1'b1; mem_rdata = 32'h2401_0001;
    settle();
    chk("fetch_c3_data_ok", {inst_data_ok, data_data_ok}, 2'b10);
    chk("fetch_c3_rdata", inst_rdata, 32'h2401_0001);
    next_cycle();
    mem_data_ok = 1'b0;
    settle();
    chk("fetch_c4_mem_req", mem_req, 0);
    next_cycle();

    // Collision: store wins, fetch follows right after the store completes
    inst_req = 1'b1; inst_addr = 32'hBFC0_0004;
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'hF;
    data_addr = 32'h0000_1000; data_wdata = 32'hDEAD_BEEF;
    next_cycle();
    mem_addr_ok = 1'b1;
    settle();
    chk("coll_c1_mem", {mem_req, mem_wr, mem_wstrb}, {1'b1, 1'b1, 4'hF});
    chk("coll_c1_addr", mem_addr, 32'h0000_1000);
    chk("coll_c1_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("coll_c1_addr_ok", {inst_addr_ok, data_addr_ok}, 2'b01);
    next_cycle();
    data_req = 1'b0; data_wr = 1'b0; mem_addr_ok = 1'b0;
    next_cycle();
    mem_data_ok = 1'b1; mem_rdata = 32'h0;
    settle();
    chk("coll_c3_data_ok", {inst_data_ok, data_data_ok}, 2'b01);
    next_cycle();
    mem_data_ok = 1'b0; mem_addr_ok = 1'b1;
    settle();
    chk("coll_c4_inst_mem", {mem_req, mem_wr, mem_wstrb}, {1'b1, 1'b0, 4'h0});
    chk("coll_c4_inst_addr", mem_addr, 32'hBFC0_0004);
    chk("coll_c4_addr_ok", {inst_addr_ok, data_addr_ok}, 2'b10);
    next_cycle();
    inst_req = 1'b0; mem_addr_ok = 1'b0;
    next_cycle();
    mem_data_ok = 1'b1; mem_rdata = 32'h1234_5678;
    settle();
    chk("coll_c6_inst_data_ok", {inst_data_ok, data_data_ok}, 2'b10);
    next_cycle();
    mem_data_ok = 1'b0;
    next_cycle();

    // Starvation: both held high, memory accepts at once and answers a cycle later
    inst_req = 1'b1; inst_addr = 32'h0000_4000;
    data_req = 1'b1; data_wr = 1'b0; data_wstrb = 4'h0; data_addr = 32'h0000_3000;
    pend = 1'b0; ng = 0;
    for (int c = 0; c < 40 && ng < 6; c++) begin
      mem_data_ok = pend;
      mem_addr_ok = mem_req;
      if (mem_req) begin
        grants[ng] = mem_addr;
        ng++;
      end
      pend = mem_req;
      next_cycle();
    end
    inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    next_cycle();
    mem_data_ok = 1'b0;
    exp_grant[0] = 32'h3000; exp_grant[1] = 32'h3000; exp_grant[2] = 32'h3000;
    exp_grant[3] = 32'h3000; exp_grant[4] = 32'h4000; exp_grant[5] = 32'h3000;
    chk("starve_grant_count", ng, 6);
    for (int i = 0; i < 6; i++) chk($sformatf("starve_grant%0d", i), grants[i], exp_grant[i]);
    next_cycle();

    // Address backpressure: request fields stay latched while memory stalls
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_1000;
    next_cycle();
    data_addr = 32'h0000_2000;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk($sformatf("bp_hold%0d", c), {mem_req, data_addr_ok, inst_addr_ok}, 3'b100);
      chk($sformatf("bp_addr%0d", c), mem_addr, 32'h0000_1000);
      next_cycle();
    end
    mem_addr_ok = 1'b1;
    settle();
    chk("bp_accept", {mem_req, data_addr_ok}, 2'b11);
    chk("bp_accept_addr", mem_addr, 32'h0000_1000);
    next_cycle();
    data_req = 1'b0; mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1; mem_rdata = 32'h55AA_33CC;
    settle();
    chk("bp_load_ok", {data_data_ok, inst_data_ok}, 2'b10);
    chk("bp_load_rdata", data_rdata, 32'h55AA_33CC);
    next_cycle();
    mem_addr_ok = 1'b1;
    settle();
    chk("idle_stray_resp", {data_data_ok, inst_data_ok, data_addr_ok, inst_addr_ok, mem_req}, 0);
    next_cycle();
    mem_data_ok = 1'b0; mem_addr_ok = 1'b0;
    next_cycle();

    // Reset while waiting for data, then a stale response
    inst_req = 1'b1; inst_addr = 32'h0000_8000;
    next_cycle();
    mem_addr_ok = 1'b1;
    settle();
    chk("rstd_addr_ok", inst_addr_ok, 1);
    next_cycle();
    inst_req = 1'b0; mem_addr_ok = 1'b0; resetn = 1'b0;
    settle();
    chk("rstd_abort", {mem_req, inst_data_ok, data_data_ok}, 0);
    chk("rstd_mem_addr", mem_addr, 0);
    next_cycle();
    resetn = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    settle();
    chk("rstd_stale", {inst_data_ok, data_data_ok, mem_req}, 0);
    next_cycle();
    mem_data_ok = 1'b0;
    settle();
    chk("rstd_idle", mem_req, 0);
    inst_req = 1'b1; inst_addr = 32'h0000_9000;
    next_cycle();
    settle();
    chk("rstd_new_req", {mem_req, mem_addr}, {1'b1, 32'h0000_9000});
    next_cycle();
    inst_req = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
